add_round_key: RTL and testbench
================================

// Module: add_round_key
// PURPOSE
//  AES AddRoundKey stage, directly downstream of mixColumns in the round datapath.
//  Holds the expanded key schedule (4*(NR+1) 32-bit words), loaded by the key-expansion logic.
//  XORs each accepted 128-bit state with the round key selected by an internal round counter.
//  One register stage with valid/ready handshake; result goes back to the round loop or out as ciphertext.
// PARAMETERS
//  NR   10  number of rounds (10/12/14 for AES-128/192/256); key bank depth = 4*(NR+1) words
//  AW   6   key-word address width; must satisfy 2**AW >= 4*(NR+1)
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  rst        in   1    reset, synchronous, active-low
//  kw_valid   in   1    key-word write strobe
//  kw_addr    in   AW   key-word index 0..4*NR+3
//  kw_data    in   32   key word w[kw_addr]
//  in_valid   in   1    upstream state valid
//  in_ready   out  1    stage can accept a state this cycle
//  in_first   in   1    qualifies in_valid: block is round 0 (initial AddRoundKey)
//  in_state   in   128  state; byte 0 = [127:120], column-major as FIPS-197
//  out_valid  out  1    out_state valid
//  out_ready  in   1    downstream accepts out_state
//  out_state  out  128  in_state XOR round key
//  out_round  out  4    round index used for out_state
//  out_final  out  1    out_round == NR (ciphertext, leave round loop)
//  zeroize    in   1    key-bank clear request (active only with ARK_ZEROIZE_EN)
//  busy       out  1    zeroize sweep in progress
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): out_valid=0, out_state=0, out_round=0, out_final=0, busy=0, rnd=0.
//    Key bank is NOT cleared by reset; in-flight block is discarded.
//  - Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] maps to [127:96].
//  - in_ready = !busy && (!out_valid || out_ready). Transfer = in_valid && in_ready.
//  - On transfer: r = in_first ? 0 : rnd; out_state <= in_state ^ key(r); out_round <= r;
//    out_final <= (r==NR); out_valid <= 1; rnd <= (r==NR) ? 0 : r+1. Latency 1 cycle.
//  - out_valid && !out_ready: out_* held stable, in_ready=0 (no overwrite).
//  - out_valid && out_ready && no transfer: out_valid <= 0 (out_* data hold last value).
//  - Simultaneous drain + transfer: full throughput, one state per cycle.
//  - Key write: w[kw_addr] <= kw_data when kw_valid and kw_addr <= 4*NR+3; else ignored.
//    Write and transfer in same cycle: transfer uses the old word; new word visible next cycle.
//  - No full state machine: states IDLE (out_valid=0), HOLD (out_valid=1), ZERO (busy=1).
// CONFIGURATION
//  ARK_ZEROIZE_EN defined: zeroize pulse (while !busy) enters ZERO for 4*(NR+1) cycles,
//    clearing w[0], w[1], ... one word per cycle; busy=1, in_ready=0, kw writes ignored,
//    rnd <= 0; a pending out_valid still drains normally. zeroize while busy is ignored.
//    Reset during ZERO aborts the sweep (partially cleared bank).
//  ARK_ZEROIZE_EN undefined: zeroize ignored, busy tied 0, no sweep logic; ports retained.
// TESTING
//  1 Load FIPS-197 App.B key 2b7e1516..09cf4f3c at w0..w3; in_first=1,
//    in_state=3243f6a8885a308d313198a2e0370734 -> next cycle out_state=193de3bea0f4e22b9ac68d2ae9f84808,
//    out_round=0, out_final=0.
//  2 Load w[4r+i]=32'h0101_0101*r; send 11 zero states back-to-back, out_ready=1 ->
//    out_round 0..10, out_state=key(r) each cycle, out_final only on round 10, next block round 0.
//  3 out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, out_state/out_round unchanged;
//    release -> one transfer per cycle resumes, no block lost or duplicated.
//  4 Write w1=deadbeef in same cycle as round-0 transfer -> result uses old w1; next round-0 block
//    uses deadbeef at [95:64]. Write to kw_addr=44 (NR=10) -> bank unchanged.
//  5 Assert in_first mid-sequence at round 6 -> out_round=0, subsequent rounds 1,2,...;
//    rst=0 with out_valid=1 -> next cycle out_valid=0, out_state=0, out_round=0.
//  6 ARK_ZEROIZE_EN: zeroize pulse -> busy=1 exactly 44 cycles, in_ready=0, then all
//    round keys 0 (out_state==in_state); undefined build -> busy stays 0, keys retained.

Source files
------------

// File: rtl/add_round_key.sv
// AES AddRoundKey register stage: key-schedule bank, round counter, valid/ready output register.
// Optional build macro ARK_ZEROIZE_EN adds a one-word-per-cycle key bank clear sweep.
module add_round_key #(
    parameter int NR = 10,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kw_valid,
    input  logic [AW-1:0] kw_addr,
    input  logic [31:0]   kw_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [127:0]  in_state,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_state,
    output logic [3:0]    out_round,
    output logic          out_final,
    input  logic          zeroize,
    output logic          busy
);
    localparam int NWORDS = 4 * (NR + 1);

    // Handshake: a state moves when in_valid && in_ready; the output register is
    // overwritten only when empty or being drained in the same cycle.
    logic [31:0]   w [NWORDS];
    logic [3:0]    rnd;
    logic [3:0]    r_sel;
    logic [AW-1:0] kbase;
    logic [127:0]  rkey;
    logic          xfer;
    logic          kw_ok;
    logic          zero_start;

    assign in_ready = !busy && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign r_sel    = in_first ? 4'd0 : rnd;
    assign kbase    = AW'({r_sel, 2'b00});
    assign kw_ok    = kw_valid && !busy && (32'(kw_addr) < 32'(NWORDS));

    always_comb begin
        rkey = {w[kbase], w[kbase + AW'(1)], w[kbase + AW'(2)], w[kbase + AW'(3)]};
    end

`ifdef ARK_ZEROIZE_EN
    logic [AW-1:0] zcnt;

    assign zero_start = zeroize && !busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            zcnt <= '0;
        end else if (zero_start) begin
            busy <= 1'b1;
            zcnt <= '0;
        end else if (busy) begin
            if (zcnt == AW'(NWORDS - 1)) busy <= 1'b0;
            else                         zcnt <= zcnt + AW'(1);
        end
    end

    // Bank has no reset; an aborted sweep deliberately leaves it partly cleared.
    always_ff @(posedge clk) begin
        if (busy)       w[zcnt]   <= '0;
        else if (kw_ok) w[kw_addr] <= kw_data;
    end
`else
    logic unused_zeroize;

    assign busy           = 1'b0;
    assign zero_start     = 1'b0;
    assign unused_zeroize = zeroize;

    always_ff @(posedge clk) begin
        if (kw_ok) w[kw_addr] <= kw_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_final <= 1'b0;
            rnd       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_state <= in_state ^ rkey;
                out_round <= r_sel;
                out_final <= (r_sel == 4'(NR));
                rnd       <= (r_sel == 4'(NR)) ? 4'd0 : r_sel + 4'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (zero_start) rnd <= '0;
        end
    end
endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key (NR=10): FIPS-197 vector, round sweep, stalls,
// key-write timing, in_first restart, reset, and the zeroize build option.
module tb_add_round_key;
    logic         clk = 1'b0;
    logic         rst;
    logic         kw_valid;
    logic [5:0]   kw_addr;
    logic [31:0]  kw_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_final;
    logic         zeroize;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    add_round_key #(.NR(10), .AW(6)) dut (
        .clk(clk), .rst(rst),
        .kw_valid(kw_valid), .kw_addr(kw_addr), .kw_data(kw_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_final(out_final),
        .zeroize(zeroize), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_kw(input logic [5:0] a, input logic [31:0] d);
        kw_valid = 1'b1;
        kw_addr  = a;
        kw_data  = d;
        tick();
        kw_valid = 1'b0;
    endtask

    function automatic logic [127:0] ramp_key(input int r);
        logic [31:0] k;
        k = 32'h0101_0101 * 32'(r);
        return {k, k, k, k};
    endfunction

    localparam logic [127:0] K0_DB = {32'h0, 32'hdeadbeef, 64'h0};
    localparam logic [127:0] S_A   = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    localparam logic [127:0] S_B   = 128'hf0e1_d2c3_b4a5_9687_7869_5a4b_3c2d_1e0f;
    localparam logic [127:0] S_C   = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

    initial begin
        int n;
        logic seen_ready;
        rst = 1'b0; kw_valid = 1'b0; kw_addr = '0; kw_data = '0;
        in_valid = 1'b0; in_first = 1'b0; in_state = '0;
        out_ready = 1'b1; zeroize = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_state", out_state, 128'h0);
        check("reset_round", 128'(out_round), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 Appendix B round 0
        write_kw(6'd0, 32'h2b7e1516);
        write_kw(6'd1, 32'h28aed2a6);
        write_kw(6'd2, 32'habf71588);
        write_kw(6'd3, 32'h09cf4f3c);
        in_valid = 1'b1; in_first = 1'b1; in_state = 128'h3243f6a8885a308d313198a2e0370734;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        check("fips_valid", 128'(out_valid), 128'(1));
        check("fips_state", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("fips_round", 128'(out_round), 128'(0));
        check("fips_final", 128'(out_final), 128'(0));

        // Ramp key schedule, 12 back-to-back blocks: rounds 0..10 then wrap to 0
        for (int i = 0; i < 44; i++) write_kw(6'(i), 32'h0101_0101 * 32'(i / 4));
        for (int r = 0; r < 12; r++) begin
            in_valid = 1'b1; in_first = (r == 0); in_state = '0;
            tick();
            check($sformatf("sweep_valid_%0d", r), 128'(out_valid), 128'(1));
            check($sformatf("sweep_round_%0d", r), 128'(out_round), 128'(r % 11));
            check($sformatf("sweep_state_%0d", r), out_state, ramp_key(r % 11));
            check($sformatf("sweep_final_%0d", r), 128'(out_final), 128'((r % 11) == 10));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 128'(out_valid), 128'(0));
        check("drain_round_hold", 128'(out_round), 128'(0));

        // Back-pressure: hold for 5 cycles, then resume without loss or duplication
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_state = S_A;
        tick();
        check("stall_first_state", out_state, S_A);
        in_first = 1'b0; in_state = S_B;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_in_ready_%0d", i), 128'(in_ready), 128'(0));
            tick();
            check($sformatf("stall_state_%0d", i), out_state, S_A);
            check($sformatf("stall_round_%0d", i), 128'(out_round), 128'(0));
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 128'(in_ready), 128'(1));
        tick();
        check("resume_state_1", out_state, S_B ^ ramp_key(1));
        check("resume_round_1", 128'(out_round), 128'(1));
        in_state = S_C;
        tick();
        check("resume_state_2", out_state, S_C ^ ramp_key(2));
        check("resume_round_2", 128'(out_round), 128'(2));
        in_valid = 1'b0;
        tick();
        check("resume_drain", 128'(out_valid), 128'(0));

        // Key write racing a round-0 transfer sees the old word
        kw_valid = 1'b1; kw_addr = 6'd1; kw_data = 32'hdeadbeef;
        in_valid = 1'b1; in_first = 1'b1; in_state = '0;
        tick();
        kw_valid = 1'b0;
        check("kw_race_old", out_state, ramp_key(0));
        tick();
        check("kw_race_new", out_state, K0_DB);
        in_valid = 1'b0;
        tick();
        write_kw(6'd44, 32'hffffffff);
        write_kw(6'd63, 32'hffffffff);
        in_valid = 1'b1; in_first = 1'b1; in_state = S_A;
        tick();
        check("kw_oob_round0", out_state, S_A ^ K0_DB);

        // in_first restart mid-sequence
        in_first = 1'b0; in_state = '0;
        for (int r = 1; r <= 5; r++) begin
            tick();
            check($sformatf("pre_restart_round_%0d", r), 128'(out_round), 128'(r));
            check($sformatf("pre_restart_state_%0d", r), out_state, ramp_key(r));
        end
        in_first = 1'b1;
        tick();
        check("restart_round", 128'(out_round), 128'(0));
        check("restart_state", out_state, K0_DB);
        in_first = 1'b0;
        tick();
        check("after_restart_round_1", 128'(out_round), 128'(1));
        tick();
        check("after_restart_round_2", 128'(out_round), 128'(2));

        // Reset with a block in flight
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1; out_ready = 1'b1;
        check("rst_flight_valid", 128'(out_valid), 128'(0));
        check("rst_flight_state", out_state, 128'h0);
        check("rst_flight_round", 128'(out_round), 128'(0));
        check("rst_flight_final", 128'(out_final), 128'(0));
        in_valid = 1'b1; in_first = 1'b0; in_state = '0;
        tick();
        check("rst_rnd_cleared", 128'(out_round), 128'(0));
        check("rst_bank_kept", out_state, K0_DB);
        in_valid = 1'b0;
        tick();

`ifdef ARK_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_busy", 128'(busy), 128'(1));
        n = 1;
        seen_ready = 1'b0;
        while (busy && n < 200) begin
            if (in_ready) seen_ready = 1'b1;
            zeroize = (n == 10);
            tick();
            if (busy) n++;
        end
        zeroize = 1'b0;
        check("zero_busy_cycles", 128'(n), 128'(44));
        check("zero_in_ready_low", 128'(seen_ready), 128'(0));
        in_valid = 1'b1; in_first = 1'b0; in_state = S_C;
        for (int r = 0; r <= 10; r++) begin
            tick();
            check($sformatf("zero_round_%0d", r), 128'(out_round), 128'(r));
            check($sformatf("zero_state_%0d", r), out_state, S_C);
        end
        in_valid = 1'b0;
        tick();
`else
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("nozero_busy", 128'(busy), 128'(0));
        check("nozero_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_first = 1'b1; in_state = S_C;
        tick();
        check("nozero_key0", out_state, S_C ^ K0_DB);
        in_first = 1'b0;
        tick();
        check("nozero_key1", out_state, S_C ^ ramp_key(1));
        in_valid = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
